// File: rtl/seg_scan_if.sv
// seg_scan_if: seven-segment scan bus inputs and decoded frame outputs
interface seg_scan_if;
  logic [5:0] sel_in;
  logic [7:0] seg_in;
  logic [7:0] addr_out;
  logic [7:0] data_out;
  logic       frame_valid;
  logic       frame_drop;
  logic       seg_err;
  logic       dp_err;
  logic       ovf;
  modport master (
    output sel_in, seg_in,
    input  addr_out, data_out, frame_valid, frame_drop, seg_err, dp_err, ovf
  );
  modport slave (
    input  sel_in, seg_in,
    output addr_out, data_out, frame_valid, frame_drop, seg_err, dp_err, ovf
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers addr/data frames from the seven-segment scan bus (optional SEG_DP_CHECK_EN)
module seg_scan_decoder #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic     clk,
  input logic     rst,
  seg_scan_if.slave bus
);
  typedef enum logic [1:0] {COLLECT, CONVERT, PUBLISH} state_t;
  state_t      state_q, state_d;
  logic [3:0]  dig_q [6];
  logic [5:0]  mask_q, mask_d;
  logic        segacc_q, segacc_d, dpacc_q, dpacc_d;
  logic [19:0] cnt_q, cnt_d;
  logic        drop_q, drop_d;
  logic [7:0]  addr_c_q, data_c_q, addr_q, data_q;
  logic        ovf_c_q, ovf_q, seg_err_q, dp_err_q, valid_q;
  logic        onehot, cap, bad, dpbad;
  logic [2:0]  pos;
  logic [3:0]  digit;
  logic [9:0]  av, dv;
  function automatic logic [4:0] dec7(input logic [6:0] s);
    case (s)
      7'h40: return 5'd0;
      7'h79: return 5'd1;
      7'h24: return 5'd2;
      7'h30: return 5'd3;
      7'h19: return 5'd4;
      7'h12: return 5'd5;
      7'h02: return 5'd6;
      7'h78: return 5'd7;
      7'h00: return 5'd8;
      7'h10: return 5'd9;
      default: return 5'h10;
    endcase
  endfunction
  // decode the bus, then frame collection, timeout and state sequencing
  always_comb begin
    onehot = bus.sel_in != 6'd0 && (bus.sel_in & (bus.sel_in - 6'd1)) == 6'd0;
    pos = 3'd0;
    for (int i = 0; i < 6; i++) if (bus.sel_in[i]) pos = 3'(i);
    cap = state_q == COLLECT && onehot;
    {bad, digit} = dec7(bus.seg_in[6:0]);
`ifdef SEG_DP_CHECK_EN
    dpbad = bus.seg_in[7] != (pos != 3'd3);
`else
    dpbad = 1'b0;
`endif
    av = 10'(dig_q[5]) * 10'd100 + 10'(dig_q[4]) * 10'd10 + 10'(dig_q[3]);
    dv = 10'(dig_q[2]) * 10'd100 + 10'(dig_q[1]) * 10'd10 + 10'(dig_q[0]);
    state_d = state_q;
    mask_d = mask_q;
    segacc_d = segacc_q;
    dpacc_d = dpacc_q;
    cnt_d = cnt_q;
    drop_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (cap) begin
          mask_d = mask_q | (6'd1 << pos);
          segacc_d = segacc_q | bad;
          dpacc_d = dpacc_q | dpbad;
          cnt_d = 20'd0;
        end else if (mask_q != 6'd0 && mask_q != 6'h3F) begin
          if (cnt_q == 20'(TIMEOUT_CYCLES - 1)) begin
            mask_d = 6'd0;
            segacc_d = 1'b0;
            dpacc_d = 1'b0;
            cnt_d = 20'd0;
            drop_d = 1'b1;
          end else cnt_d = cnt_q + 20'd1;
        end
        state_d = mask_q == 6'h3F ? CONVERT : COLLECT;
      end
      CONVERT: state_d = PUBLISH;
      default: begin
        state_d = COLLECT;
        mask_d = 6'd0;
        segacc_d = 1'b0;
        dpacc_d = 1'b0;
        cnt_d = 20'd0;
      end
    endcase
  end
  // state, capture registers, conversion and published outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      dig_q <= '{default: '0};
      mask_q <= 6'd0;
      segacc_q <= 1'b0;
      dpacc_q <= 1'b0;
      cnt_q <= 20'd0;
      drop_q <= 1'b0;
      addr_c_q <= 8'd0;
      data_c_q <= 8'd0;
      ovf_c_q <= 1'b0;
      addr_q <= 8'd0;
      data_q <= 8'd0;
      ovf_q <= 1'b0;
      seg_err_q <= 1'b0;
      dp_err_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      segacc_q <= segacc_d;
      dpacc_q <= dpacc_d;
      cnt_q <= cnt_d;
      drop_q <= drop_d;
      valid_q <= state_q == PUBLISH;
      if (cap) dig_q[pos] <= bad ? 4'd0 : digit;
      if (state_q == CONVERT) begin
        addr_c_q <= av > 10'd255 ? 8'hFF : av[7:0];
        data_c_q <= dv > 10'd255 ? 8'hFF : dv[7:0];
        ovf_c_q <= av > 10'd255 || dv > 10'd255;
      end
      if (state_q == PUBLISH) begin
        addr_q <= addr_c_q;
        data_q <= data_c_q;
        ovf_q <= ovf_c_q;
        seg_err_q <= segacc_q;
        dp_err_q <= dpacc_q;
      end
    end
  end
  assign bus.addr_out = addr_q;
  assign bus.data_out = data_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_drop = drop_q;
  assign bus.seg_err = seg_err_q;
  assign bus.dp_err = dp_err_q;
  assign bus.ovf = ovf_q;
endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Recovers the address and data values from the multiplexed seven-segment bus that feeds the storage-tube display. It watches the registered digit-select and segment lines, decodes each active-low segment pattern back to a BCD digit, and collects all six digit positions into one frame. When a frame is complete it converts the digits to binary and publishes the address and data with status flags. It sits beside the display driver as a readback and self-check monitor for the RAM display path.

## Interface
- `TIMEOUT_CYCLES`, default 100000: idle cycles with a partial frame before that frame is discarded. Range 2..2^20-1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `sel_in`  in  6  digit select, one-hot. Bit0/1/2 = data ones/tens/hundreds; bit3/4/5 = addr ones/tens/hundreds.
- `seg_in`  in  8  segment pattern, active-low. Bit7 = dp, bits6..0 = g..a.
- `addr_out`  out  8  decoded address, held until the next publish.
- `data_out`  out  8  decoded data, held until the next publish.
- `frame_valid`  out  1  one-cycle pulse when `addr_out`/`data_out`/flags update.
- `frame_drop`  out  1  one-cycle pulse when a partial frame times out.
- `seg_err`  out  1  an unrecognised digit pattern occurred in the published frame.
- `dp_err`  out  1  dp placement was wrong in the published frame.
- `ovf`  out  1  a decoded value exceeded 255 and was saturated.

## Operation
- Digit table on `seg_in[6:0]`:
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19
  - 5 = 7'h12, 6 = 7'h02, 7 = 7'h78, 8 = 7'h00, 9 = 7'h10
  - Any other pattern stores digit 0 and sets the frame's `seg_err` accumulator.
- States: COLLECT, CONVERT, PUBLISH.
- COLLECT:
  - Each cycle where `sel_in` is exactly one-hot, decode `seg_in` into that position's digit register and set its bit in a 6-bit capture mask.
  - A repeated position overwrites the earlier capture; the newest value wins.
  - `sel_in` = 0 or multi-hot is ignored: no capture, no error.
- When the mask reaches 6'b111111, go to CONVERT on the next cycle.
- CONVERT:
  - `v = h*100 + t*10 + o` for the addr set and the data set separately, with 10-bit intermediates.
  - A value greater than 255 saturates to 255 and sets `ovf`.
- PUBLISH:
  - Register `addr_out`, `data_out`, `seg_err`, `dp_err` and `ovf`; pulse `frame_valid`.
  - Clear the mask and the error accumulators; return to COLLECT.
- Inputs are ignored during CONVERT and PUBLISH.
- Timeout:
  - In COLLECT, an idle counter clears on every capture and increments while the mask is nonzero.
  - When it reaches `TIMEOUT_CYCLES`: clear the mask and accumulators, pulse `frame_drop`, leave the outputs unchanged.
  - A capture on the same cycle as the timeout wins: the counter clears and no drop occurs.
- Reset: all outputs 0, mask 0, counter 0, state COLLECT.
- Reset asserted mid-frame or during CONVERT/PUBLISH aborts with no `frame_valid`.

## Timing
- Capture is registered: `sel_in`/`seg_in` sampled at edge N updates the mask at N.
- The CONVERT transition happens at N+1 after the capture that completes the mask.
- PUBLISH at N+2. `frame_valid` is high during cycle N+3, with the outputs valid the same cycle.
- End-to-end latency from the last digit to `frame_valid` is 3 cycles.
- Minimum frame spacing is 6 capture cycles plus 2 cycles of dead time.
- Flags are level outputs, changing only at publish or reset.

## Configuration
- `SEG_DP_CHECK_EN` defined:
  - Position 3 must have `seg_in[7]` = 0 (dp lit); all other positions must have `seg_in[7]` = 1.
  - Any violation sets the frame's `dp_err`.
- `SEG_DP_CHECK_EN` undefined:
  - `seg_in[7]` is ignored.
  - `dp_err` is constant 0.

## Test plan
- Scan addr 123 / data 45 in order bit0..bit5 with correct dp -> `frame_valid` 3 cycles after the bit5 capture; `addr_out` = 123, `data_out` = 45, all flags 0.
- Scan data hundreds/tens/ones as 9/9/9 -> `data_out` = 255, `ovf` = 1.
- Data-ones pattern 8'hFF, other digits valid -> `seg_err` = 1 and that digit decodes as 0.
- With the macro defined, dp lit on position 0 -> `dp_err` = 1. With the macro undefined, the same stimulus -> `dp_err` = 0.
- `TIMEOUT_CYCLES` = 8, send 3 digits then `sel_in` = 0 for 8 cycles -> one `frame_drop` pulse; outputs unchanged; the next full scan publishes correctly.
- Assert `rst` for 1 cycle after 5 digits, then send the 6th digit alone -> no `frame_valid`, all outputs 0.
